// File: rtl/mod_exp_priv.sv
// Constant-time modular exponentiator res = c^d mod n. It uses left-to-right square-and-always-multiply
// on a single bit-serial radix-2 Montgomery multiplier that is sequenced by a small FSM.
module mod_exp_priv #(
   parameter int LEN  = 2048,
   parameter int DLEN = LEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [LEN-1:0]  c,
   input  logic [DLEN-1:0] d,
   input  logic [LEN-1:0]  n,
   input  logic [LEN-1:0]  r2_mod_n,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [LEN-1:0]  res
);

   localparam int SW = LEN + 2;
   localparam int CW = $clog2(LEN + 2);
   localparam int JW = (DLEN > 1) ? $clog2(DLEN) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(LEN + 1);
   localparam logic [JW-1:0] J_TOP    = JW'(DLEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EVEN,
      S_PRE_C,
      S_PRE_X,
      S_SQR,
      S_MUL,
      S_POST,
      S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_next;

   logic [LEN-1:0]  r_c;
   logic [LEN-1:0]  r_n;
   logic [LEN-1:0]  r_r2;
   logic [LEN-1:0]  r_cb;
   logic [LEN-1:0]  r_x;
   logic [LEN-1:0]  r_a;
   logic [LEN-1:0]  r_res;
   logic [DLEN-1:0] r_d;
   logic [SW-1:0]   r_s;
   logic [CW-1:0]   r_cnt;
   logic [JW-1:0]   r_j;
   logic            r_err;

   logic            w_accept;
   logic            w_mm_active;
   logic            w_mm_last;
   logic [LEN-1:0]  w_op_a;
   logic [LEN-1:0]  w_op_b;
   logic [SW-1:0]   w_s_iter;
   logic [LEN-1:0]  w_mm_res;

   // One interleaved iteration: S = (S + a0*B [+ n]) / 2, keeping S even before the halving.
   function automatic logic [SW-1:0] mont_step(input logic [SW-1:0]  s,
                                               input logic           a0,
                                               input logic [LEN-1:0] b,
                                               input logic [LEN-1:0] m);
      logic [SW-1:0] t;
      t = s + (a0 ? {2'b00, b} : {SW{1'b0}});
      if (t[0]) begin
         t = t + {2'b00, m};
      end
      return t >> 1;
   endfunction

   function automatic logic [LEN-1:0] final_reduce(input logic [SW-1:0]  s,
                                                   input logic [LEN-1:0] m);
      logic [SW-1:0] t;
      t = (s >= {2'b00, m}) ? (s - {2'b00, m}) : s;
      return t[LEN-1:0];
   endfunction

   assign w_accept    = (r_state == S_IDLE) && start;
   assign w_mm_active = (r_state == S_PRE_C) || (r_state == S_PRE_X) || (r_state == S_SQR) ||
                        (r_state == S_MUL)   || (r_state == S_POST);
   assign w_mm_last   = w_mm_active && (r_cnt == CNT_LAST);
   assign w_s_iter    = mont_step(r_s, r_a[0], w_op_b, r_n);
   assign w_mm_res    = final_reduce(r_s, r_n);

   // Operand selection; both operands stay stable for the whole multiply.
   always_comb begin
      w_op_a = '0;
      w_op_b = '0;
      case (r_state)
         S_PRE_C: begin
            w_op_a = r_c;
            w_op_b = r_r2;
         end
         S_PRE_X: begin
            w_op_a = LEN'(1);
            w_op_b = r_r2;
         end
         S_SQR: begin
            w_op_a = r_x;
            w_op_b = r_x;
         end
         S_MUL: begin
            w_op_a = r_x;
            w_op_b = r_cb;
         end
         S_POST: begin
            w_op_a = r_x;
            w_op_b = LEN'(1);
         end
         default: begin
            w_op_a = '0;
            w_op_b = '0;
         end
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = n[0] ? S_PRE_C : S_EVEN;
         S_EVEN:  w_next = S_DONE;
         S_PRE_C: if (w_mm_last) w_next = S_PRE_X;
         S_PRE_X: if (w_mm_last) w_next = S_SQR;
         S_SQR:   if (w_mm_last) w_next = S_MUL;
         S_MUL:   if (w_mm_last) w_next = (r_j == '0) ? S_POST : S_SQR;
         S_POST:  if (w_mm_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_c   <= '0;
         r_n   <= '0;
         r_r2  <= '0;
         r_cb  <= '0;
         r_x   <= '0;
         r_a   <= '0;
         r_res <= '0;
         r_d   <= '0;
         r_s   <= '0;
         r_cnt <= '0;
         r_j   <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_c   <= c;
            r_d   <= d;
            r_n   <= n;
            r_r2  <= r2_mod_n;
            r_err <= ~n[0];
            if (!n[0]) begin
               r_res <= '0;
            end
         end

         if (w_mm_active) begin
            r_cnt <= w_mm_last ? '0 : (r_cnt + CW'(1));
            if (r_cnt == '0) begin
               r_s <= '0;
               r_a <= w_op_a;
            end else if (!w_mm_last) begin
               r_s <= w_s_iter;
               r_a <= r_a >> 1;
            end
         end else begin
            r_cnt <= '0;
         end

         // Multiply-complete write-back; the exponent is consumed MSB first by shifting.
         if (w_mm_last) begin
            case (r_state)
               S_PRE_C: r_cb <= w_mm_res;
               S_PRE_X: begin
                  r_x <= w_mm_res;
                  r_j <= J_TOP;
               end
               S_SQR:   r_x <= w_mm_res;
               S_MUL: begin
                  if (r_d[DLEN-1]) begin
                     r_x <= w_mm_res;
                  end
                  r_d <= r_d << 1;
                  r_j <= r_j - JW'(1);
               end
               S_POST:  r_res <= w_mm_res;
               default: r_res <= r_res;
            endcase
         end
      end
   end

   assign busy = w_mm_active;
   assign done = (r_state == S_DONE);
   assign err  = r_err;
   assign res  = r_res;

endmodule

// File: tb/tb_mod_exp_priv.sv
// Bench for mod_exp_priv: directed LEN=8 vectors and corner sequences, plus a randomized LEN=16
// regression that is checked against a square-and-multiply reference and a fixed latency.
module tb_mod_exp_priv;

   localparam int LAT8  = (2 * 8 + 3) * (8 + 2);
   localparam int LAT16 = (2 * 16 + 3) * (16 + 2);

   logic        clk;
   logic        rst;

   logic        s8_start;
   logic [7:0]  s8_c, s8_d, s8_n, s8_r2, s8_res;
   logic        s8_busy, s8_done, s8_err;

   logic        s16_start;
   logic [15:0] s16_c, s16_d, s16_n, s16_r2, s16_res;
   logic        s16_busy, s16_done, s16_err;

   int tests;
   int fails;

   mod_exp_priv #(.LEN(8), .DLEN(8)) u8 (
      .clk(clk), .rst(rst), .start(s8_start), .c(s8_c), .d(s8_d), .n(s8_n),
      .r2_mod_n(s8_r2), .busy(s8_busy), .done(s8_done), .err(s8_err), .res(s8_res));

   mod_exp_priv #(.LEN(16), .DLEN(16)) u16 (
      .clk(clk), .rst(rst), .start(s16_start), .c(s16_c), .d(s16_d), .n(s16_n),
      .r2_mod_n(s16_r2), .busy(s16_busy), .done(s16_done), .err(s16_err), .res(s16_res));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      logic [7:0] c;
      logic [7:0] d;
      logic [7:0] exp_res;
   } vec_t;

   vec_t vt[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic longint modpow(input longint b, input longint e, input longint m);
      longint r;
      longint bb;
      r  = 1;
      bb = b % m;
      for (int k = 15; k >= 0; k--) begin
         r = (r * r) % m;
         if (e[k]) r = (r * bb) % m;
      end
      return r % m;
   endfunction

   task automatic run8(input logic [7:0] cc, input logic [7:0] dd, output int lat,
                       output logic busy_ok, output logic pulse_ok);
      @(negedge clk);
      s8_c = cc; s8_d = dd; s8_n = 8'd187; s8_r2 = 8'd86; s8_start = 1'b1;
      @(posedge clk); #1;
      s8_start = 1'b0;
      lat = 0;
      busy_ok = (s8_busy === 1'b1);
      while (s8_done !== 1'b1 && lat < 1000) begin
         @(posedge clk); #1;
         lat++;
         if (s8_done !== 1'b1 && s8_busy !== 1'b1) busy_ok = 1'b0;
      end
      if (s8_busy !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      pulse_ok = (s8_done === 1'b0);
   endtask

   task automatic run16(input logic [15:0] cc, input logic [15:0] dd, input logic [15:0] nn,
                        input logic [15:0] rr, output int lat, output logic busy_ok);
      @(negedge clk);
      s16_c = cc; s16_d = dd; s16_n = nn; s16_r2 = rr; s16_start = 1'b1;
      @(posedge clk); #1;
      s16_start = 1'b0;
      lat = 0;
      busy_ok = (s16_busy === 1'b1);
      while (s16_done !== 1'b1 && lat < 2000) begin
         @(posedge clk); #1;
         lat++;
         if (s16_done !== 1'b1 && s16_busy !== 1'b1) busy_ok = 1'b0;
      end
      if (s16_busy !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int   lat;
      logic bok, pok;
      logic [15:0] rn, rc, rd, rr;
      longint exp16;

      tests = 0; fails = 0;
      vt[0] = '{8'd11,  8'd23, 8'd88};
      vt[1] = '{8'd88,  8'd7,  8'd11};
      vt[2] = '{8'd5,   8'd0,  8'd1};
      vt[3] = '{8'd5,   8'd1,  8'd5};
      vt[4] = '{8'd0,   8'd23, 8'd0};
      vt[5] = '{8'd2,   8'd10, 8'd89};
      vt[6] = '{8'd186, 8'd2,  8'd1};

      rst = 1'b1;
      s8_start = 0; s8_c = 0; s8_d = 0; s8_n = 8'd187; s8_r2 = 8'd86;
      s16_start = 0; s16_c = 0; s16_d = 0; s16_n = 16'd3; s16_r2 = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", s8_busy, 0);
      chk("reset_done", s8_done, 0);
      chk("reset_err", s8_err, 0);
      chk("reset_res", s8_res, 0);
      chk("reset_busy16", s16_busy, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         run8(vt[i].c, vt[i].d, lat, bok, pok);
         chk($sformatf("vec%0d_res", i), s8_res, vt[i].exp_res);
         chk($sformatf("vec%0d_err", i), s8_err, 0);
         chk($sformatf("vec%0d_latency", i), lat, LAT8);
         chk($sformatf("vec%0d_busy", i), bok, 1);
         chk($sformatf("vec%0d_done_pulse", i), pok, 1);
      end

      // Back-to-back jobs with start held high throughout.
      @(negedge clk);
      s8_c = 8'd88; s8_d = 8'd7; s8_n = 8'd187; s8_r2 = 8'd86; s8_start = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      while (s8_done !== 1'b1 && lat < 1000) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("b2b_first_latency", lat, LAT8);
      chk("b2b_first_res", s8_res, 11);
      s8_c = 8'd11; s8_d = 8'd23;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (s8_done !== 1'b1 && lat < 1000);
      s8_start = 1'b0;
      chk("b2b_second_spacing", lat, LAT8 + 2);
      chk("b2b_second_res", s8_res, 88);
      repeat (2) @(posedge clk);
      #1;
      chk("b2b_no_third_job", s8_busy, 0);

      // Even modulus: immediate error completion.
      @(negedge clk);
      s8_c = 8'd11; s8_d = 8'd23; s8_n = 8'd186; s8_start = 1'b1;
      @(posedge clk); #1;
      s8_start = 1'b0;
      chk("even_busy_accept", s8_busy, 0);
      chk("even_done_early", s8_done, 0);
      @(posedge clk); #1;
      chk("even_done", s8_done, 1);
      chk("even_err", s8_err, 1);
      chk("even_res", s8_res, 0);
      chk("even_busy", s8_busy, 0);
      @(posedge clk); #1;
      chk("even_done_pulse", s8_done, 0);

      run8(8'd5, 8'd1, lat, bok, pok);
      chk("after_even_res", s8_res, 5);
      chk("after_even_err", s8_err, 0);

      // Reset in the middle of a MUL phase.
      @(negedge clk);
      s8_c = 8'd11; s8_d = 8'd23; s8_n = 8'd187; s8_r2 = 8'd86; s8_start = 1'b1;
      @(posedge clk); #1;
      s8_start = 1'b0;
      repeat (99) @(posedge clk);
      @(negedge clk);
      chk("midrst_busy_before", s8_busy, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_busy", s8_busy, 0);
      chk("midrst_done", s8_done, 0);
      chk("midrst_res", s8_res, 0);
      chk("midrst_err", s8_err, 0);
      @(negedge clk);
      rst = 1'b0;

      // Fresh job; a start pulse and input changes while busy must be ignored.
      @(negedge clk);
      s8_c = 8'd11; s8_d = 8'd23; s8_n = 8'd187; s8_r2 = 8'd86; s8_start = 1'b1;
      @(posedge clk); #1;
      s8_start = 1'b0;
      lat = 0;
      while (s8_done !== 1'b1 && lat < 1000) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 50) begin
            s8_start = 1'b1; s8_c = 8'd5; s8_d = 8'd1; s8_n = 8'd185; s8_r2 = 8'd3;
         end
         if (lat == 51) s8_start = 1'b0;
      end
      chk("fresh_latency", lat, LAT8);
      chk("fresh_res", s8_res, 88);
      chk("fresh_err", s8_err, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("fresh_no_extra_job", s8_busy, 0);

      // Randomized LEN=16 regression against the reference model.
      for (int i = 0; i < 20; i++) begin
         if (i == 0) rn = 16'd1;
         else        rn = 16'($urandom_range(65535, 3)) | 16'd1;
         rc = (rn > 16'd1) ? 16'($urandom % rn) : 16'd0;
         if (i == 1)      rd = 16'd0;
         else if (i == 2) rd = 16'hFFFF;
         else if (i == 3) rd = 16'd1;
         else             rd = 16'($urandom_range(65535, 0));
         rr = 16'((64'd1 << 32) % {48'd0, rn});
         run16(rc, rd, rn, rr, lat, bok);
         chk($sformatf("rand%0d_latency", i), lat, LAT16);
         chk($sformatf("rand%0d_busy", i), bok, 1);
         if (rn != 16'd1) begin
            exp16 = modpow(longint'(rc), longint'(rd), longint'(rn));
            chk($sformatf("rand%0d_res n=%0d c=%0d d=%0d", i, rn, rc, rd), s16_res, exp16);
            chk($sformatf("rand%0d_err", i), s16_err, 0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mod_exp_priv.md
Name: mod_exp_priv

Overview:
- Sequential modular exponentiator `res = c^d mod n` with a runtime private exponent `d`. It is the decrypt/sign counterpart of the fixed-public-exponent combinational exponentiator.
- Uses one internal bit-serial (radix-2 interleaved) Montgomery multiplier, reused under an FSM, with a start/done handshake.
- Constant-time: always processes all DLEN exponent bits, with a multiply on every bit.
- Sits behind the RSA/ECC control logic. Inputs are latched at start, so the source may change them while the block is busy.

Parameters:
- LEN, 2048, operand/modulus width in bits; Montgomery R = 2^LEN.
- DLEN, LEN, exponent width in bits; scanned MSB to LSB.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; synchronous and active-high.
- start  input  1  request; accepted only in IDLE.
- c  input  LEN  base; must be < n.
- d  input  DLEN  private exponent.
- n  input  LEN  modulus; must be odd and > 1.
- r2_mod_n  input  LEN  R^2 mod n, precomputed by the caller.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse when res is valid.
- err  output  1  valid with done; 1 means n is even.
- res  output  LEN  result; held until the next accepted start.

Behaviour:
- Reset (synchronous, active-high, any state, including mid-operation): state to IDLE; busy, done, err = 0; res = 0; all internal registers cleared; the in-flight job is discarded.
- Acceptance: start=1 in IDLE at edge k latches c, d, n, r2_mod_n. Start while busy or in DONE is ignored.
- Even n: if n[0]=0 at acceptance, go to DONE. done=1 and err=1 at edge k+1; res=0.
- Montgomery multiply MM(A,B) = A·B·R^-1 mod n, taking exactly LEN+2 cycles:
  - 1 load cycle: S=0.
  - LEN iteration cycles, i = 0..LEN-1: S = S + A[i]·B; if S odd then S = S + n; S = S >> 1.
  - 1 final cycle: if S ≥ n then S = S − n.
  - S is LEN+2 bits wide. The result is always < n when A, B < n.
- FSM sequence (each state runs one MM):
  - PRE_C: cb = MM(c, r2_mod_n).
  - PRE_X: x = MM(1, r2_mod_n), i.e. R mod n.
  - Then for j = DLEN-1 down to 0:
    - SQR: x = MM(x, x).
    - MUL: t = MM(x, cb); if d[j]=1 then x = t. The multiply runs regardless of d[j].
  - POST: res = MM(x, 1).
  - DONE: done=1 for one cycle, err=0, then IDLE.
- Latency: accepted at edge k → done high after edge k + (2·DLEN+3)·(LEN+2). busy=1 throughout, falling in the same cycle done rises.
- Boundaries:
  - d=0 → res = 1, with unchanged latency.
  - d=1 → res = c.
  - c=0 → res = 0 for d ≠ 0.
  - c ≥ n or n=1: result unspecified, but the FSM must still terminate with the normal latency.
  - start held high continuously → a new job is accepted in the IDLE cycle that follows DONE.
- res updates only at the POST completion edge (or cleared for err); stable otherwise.

Test Plan:
- LEN=8, DLEN=8, n=187, r2_mod_n=86, c=11, d=23 → res=88, err=0, done exactly 190 cycles after acceptance, busy high for those cycles.
- Same setup, c=88, d=7 → res=11; then back-to-back with start held high, second job c=11, d=23 → res=88 with no dropped cycle.
- n=187, c=5, d=0 → res=1; d=1 → res=5; c=0, d=23 → res=0; all at 190 cycles.
- n=186 (even), any c/d → done at accept+1 with err=1, res=0, busy never asserted.
- Assert rst mid-MUL at cycle 100 of a job → next edge busy=0, done=0, res=0. A fresh start (c=11, d=23) then gives res=88 at 190 cycles. A start pulse during busy is ignored, and inputs changed while busy do not affect res.
- Random regression: LEN=16, random odd n, c<n, random d → compare against a software modpow model. Check the constant latency (2·DLEN+3)·(LEN+2) for every d.
